// File: rtl/multi_receiver_ctrl_pkg.sv
// rtl/multi_receiver_ctrl_pkg.sv - shared types and default constants for the receiver controller
package multi_receiver_ctrl_pkg;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_RECEIVE = 2'd1,
        RX_HOLD    = 2'd2
    } rx_ch_state_t;

    localparam int RX_NUM_CH         = 2;
    localparam int RX_WAIT_CYCLES    = 1;
    localparam int RX_TIMEOUT_CYCLES = 1_000_000;
    localparam int RX_CNT_W          = 16;

endpackage

// File: rtl/multi_receiver_ctrl_fsm.sv
// rtl/multi_receiver_ctrl_fsm.sv - one receiver channel: arm/hold FSM, watchdog, packet counter, flags
module receiver_channel_fsm
    import multi_receiver_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES    = RX_WAIT_CYCLES,
    parameter int TIMEOUT_CYCLES = RX_TIMEOUT_CYCLES,
    parameter int CNT_W          = RX_CNT_W
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             act,
    input  logic             receive_done,
    input  logic             clear_stats,
    output logic             receive_start,
    output logic             timeout,
    output logic             seen,
    output logic [CNT_W-1:0] pkt_count
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int HD_W = ($clog2(WAIT_CYCLES + 1) > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HD_W-1:0]  HD_LOAD = HD_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    rx_ch_state_t     state_q, state_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic [HD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
    logic             seen_q, seen_d;
    logic             start_c;
    logic             pkt_inc;
    logic             wd_expire;

    // State and statistics registers
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= RX_IDLE;
            wdog_q    <= '0;
            hold_q    <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdog_q    <= wdog_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            seen_q    <= seen_d;
        end
    end

    // Next-state, Mealy start pulse, watchdog/hold counters and stats updates
    always_comb begin
        state_d   = state_q;
        wdog_d    = wdog_q;
        hold_d    = hold_q;
        timeout_d = timeout_q;
        seen_d    = seen_q;
        start_c   = 1'b0;
        pkt_inc   = 1'b0;
        wd_expire = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (act) begin
                    state_d   = RX_RECEIVE;
                    start_c   = 1'b1;
                    wdog_d    = '0;
                    timeout_d = 1'b0;
                    seen_d    = 1'b0;
                end
            end
            RX_RECEIVE: begin
                if (!act) begin
                    state_d = RX_IDLE;
                end else if (receive_done) begin
                    state_d = RX_HOLD;
                    pkt_inc = 1'b1;
                    seen_d  = 1'b1;
                    hold_d  = HD_LOAD;
                end else if (wdog_q == WD_LAST) begin
                    wd_expire = 1'b1;
                    start_c   = 1'b1;
                    wdog_d    = '0;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            RX_HOLD: begin
                if (!act) begin
                    state_d = RX_IDLE;
                end else if (hold_q == '0) begin
                    state_d = RX_RECEIVE;
                    start_c = 1'b1;
                    wdog_d  = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // Clear beats a same-cycle packet; a same-cycle watchdog expiry beats clear
        cnt_d = cnt_q;
        if (pkt_inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (clear_stats) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
        end
        if (wd_expire) begin
            timeout_d = 1'b1;
        end
    end

    // The start pulse is combinational from act, so gate it while reset is held
    assign receive_start = start_c & rst_l;
    assign timeout       = timeout_q;
    assign seen          = seen_q;
    assign pkt_count     = cnt_q;

endmodule

// File: rtl/multi_receiver_ctrl.sv
// rtl/multi_receiver_ctrl.sv - control for NUM_CH serial receivers with watchdog, stats and link status
module multi_receiver_ctrl
    import multi_receiver_ctrl_pkg::*;
#(
    parameter int NUM_CH         = RX_NUM_CH,
    parameter int WAIT_CYCLES    = RX_WAIT_CYCLES,
    parameter int TIMEOUT_CYCLES = RX_TIMEOUT_CYCLES,
    parameter int CNT_W          = RX_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_l,
    input  logic                    game_active,
    input  logic [NUM_CH-1:0]       ch_enable,
    input  logic [NUM_CH-1:0]       receive_done,
    input  logic                    clear_stats,
    output logic [NUM_CH-1:0]       receive_start,
    output logic [NUM_CH-1:0]       timeout,
    output logic [NUM_CH*CNT_W-1:0] pkt_count,
    output logic                    link_up
);

    logic [NUM_CH-1:0] act;
    logic [NUM_CH-1:0] seen;
    logic              link_d;

    assign act = {NUM_CH{game_active}} & ch_enable;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        receiver_channel_fsm #(
            .WAIT_CYCLES    (WAIT_CYCLES),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk           (clk),
            .rst_l         (rst_l),
            .act           (act[g]),
            .receive_done  (receive_done[g]),
            .clear_stats   (clear_stats),
            .receive_start (receive_start[g]),
            .timeout       (timeout[g]),
            .seen          (seen[g]),
            .pkt_count     (pkt_count[g*CNT_W +: CNT_W])
        );
    end

    // Link is healthy when some channel is active and every active channel has a packet and no timeout
    always_comb begin
        link_d = (|act) && ((act & (~seen | timeout)) == '0);
    end

    // Registered aggregate link status
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            link_up <= 1'b0;
        end else begin
            link_up <= link_d;
        end
    end

endmodule

// File: tb/tb_multi_receiver_ctrl.sv
// tb/tb_multi_receiver_ctrl.sv - randomized self-checking bench for multi_receiver_ctrl
module tb_multi_receiver_ctrl;

    localparam int NCH     = 2;
    localparam int WAIT    = 3;
    localparam int TMO     = 20;
    localparam int CW      = 4;
    localparam int CMAX    = 15;
    localparam int CYC_PER = 500;

    localparam int M_IDLE   = 0;
    localparam int M_LISTEN = 1;
    localparam int M_HOLD   = 2;

    logic              clk = 1'b0;
    logic              rst_l;
    logic              game_active;
    logic [NCH-1:0]    ch_enable;
    logic [NCH-1:0]    receive_done;
    logic              clear_stats;
    logic [NCH-1:0]    receive_start;
    logic [NCH-1:0]    timeout;
    logic [NCH*CW-1:0] pkt_count;
    logic              link_up;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: mode, cycles listened since arm, hold cycles left, stats
    int m_mode [NCH];
    int m_age  [NCH];
    int m_hold [NCH];
    int m_cnt  [NCH];
    bit m_to   [NCH];
    bit m_seen [NCH];
    int n_mode [NCH];
    int n_age  [NCH];
    int n_hold [NCH];
    int n_cnt  [NCH];
    bit n_to   [NCH];
    bit n_seen [NCH];
    logic [NCH-1:0] exp_start;
    logic           exp_link;

    multi_receiver_ctrl #(
        .NUM_CH         (NCH),
        .WAIT_CYCLES    (WAIT),
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .game_active   (game_active),
        .ch_enable     (ch_enable),
        .receive_done  (receive_done),
        .clear_stats   (clear_stats),
        .receive_start (receive_start),
        .timeout       (timeout),
        .pkt_count     (pkt_count),
        .link_up       (link_up)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = M_IDLE;
            m_age[i]  = 0;
            m_hold[i] = 0;
            m_cnt[i]  = 0;
            m_to[i]   = 1'b0;
            m_seen[i] = 1'b0;
        end
        exp_link = 1'b0;
    endtask

    // Predict this cycle's start pulses and the state after the coming edge
    task automatic model_predict();
        bit a, arm, pkt, expire;
        for (int i = 0; i < NCH; i++) begin
            a      = game_active & ch_enable[i];
            arm    = 1'b0;
            pkt    = 1'b0;
            expire = 1'b0;
            n_mode[i] = m_mode[i];
            n_age[i]  = m_age[i];
            n_hold[i] = m_hold[i];
            n_seen[i] = m_seen[i];
            exp_start[i] = 1'b0;
            if (m_mode[i] == M_IDLE) begin
                if (a) begin
                    n_mode[i] = M_LISTEN;
                    n_age[i]  = 0;
                    n_seen[i] = 1'b0;
                    arm = 1'b1;
                    exp_start[i] = 1'b1;
                end
            end else if (!a) begin
                n_mode[i] = M_IDLE;
            end else if (m_mode[i] == M_LISTEN) begin
                if (receive_done[i]) begin
                    pkt = 1'b1;
                    n_seen[i] = 1'b1;
                    n_mode[i] = M_HOLD;
                    n_hold[i] = WAIT;
                end else if (m_age[i] == TMO - 1) begin
                    expire = 1'b1;
                    n_age[i] = 0;
                    exp_start[i] = 1'b1;
                end else begin
                    n_age[i] = m_age[i] + 1;
                end
            end else begin
                if (m_hold[i] == 1) begin
                    n_mode[i] = M_LISTEN;
                    n_age[i]  = 0;
                    exp_start[i] = 1'b1;
                end else begin
                    n_hold[i] = m_hold[i] - 1;
                end
            end
            if (clear_stats) n_cnt[i] = 0;
            else if (pkt)    n_cnt[i] = (m_cnt[i] + 1 > CMAX) ? CMAX : m_cnt[i] + 1;
            else             n_cnt[i] = m_cnt[i];
            if (expire)                   n_to[i] = 1'b1;
            else if (arm || clear_stats)  n_to[i] = 1'b0;
            else                          n_to[i] = m_to[i];
        end
    endtask

    task automatic model_commit();
        bit any_act, healthy;
        any_act = 1'b0;
        healthy = 1'b1;
        for (int i = 0; i < NCH; i++) begin
            if (game_active & ch_enable[i]) begin
                any_act = 1'b1;
                if (!m_seen[i] || m_to[i]) healthy = 1'b0;
            end
        end
        exp_link = any_act & healthy;
        for (int i = 0; i < NCH; i++) begin
            m_mode[i] = n_mode[i];
            m_age[i]  = n_age[i];
            m_hold[i] = n_hold[i];
            m_cnt[i]  = n_cnt[i];
            m_to[i]   = n_to[i];
            m_seen[i] = n_seen[i];
        end
    endtask

    task automatic check_outputs(input string where);
        logic [NCH-1:0]    e_to;
        logic [NCH*CW-1:0] e_cnt;
        for (int i = 0; i < NCH; i++) begin
            e_to[i] = m_to[i];
            e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
        end
        check_val({where, " receive_start"}, 32'(receive_start), 32'(exp_start));
        check_val({where, " timeout"},       32'(timeout),       32'(e_to));
        check_val({where, " pkt_count"},     32'(pkt_count),     32'(e_cnt));
        check_val({where, " link_up"},       32'(link_up),       32'(exp_link));
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    task automatic check_reset_zero(input string where);
        check_val({where, " receive_start"}, 32'(receive_start), 32'h0);
        check_val({where, " timeout"},       32'(timeout),       32'h0);
        check_val({where, " pkt_count"},     32'(pkt_count),     32'h0);
        check_val({where, " link_up"},       32'(link_up),       32'h0);
    endtask

    initial begin
        rst_l        = 1'b0;
        game_active  = 1'b1;
        ch_enable    = 2'b11;
        receive_done = '0;
        clear_stats  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_zero("reset");
        @(posedge clk);
        #1;
        rst_l       = 1'b1;
        game_active = 1'b0;

        for (int ph = 0; ph < 6; ph++) begin
            if (ph == 3) begin
                game_active = 1'b1;
                ch_enable   = 2'b11;
                rst_l       = 1'b0;
                #1;
                check_reset_zero("async_reset");
                @(posedge clk);
                #1;
                rst_l = 1'b1;
                model_reset();
            end
            for (int c = 0; c < CYC_PER; c++) begin
                case (ph)
                    0: begin
                        game_active  = (c > 2);
                        ch_enable    = 2'b11;
                        receive_done = {pct(15), pct(15)};
                        clear_stats  = pct(1);
                    end
                    1: begin
                        game_active  = 1'b1;
                        ch_enable    = 2'b01;
                        receive_done = {pct(30), pct(25)};
                        clear_stats  = pct(1);
                    end
                    2: begin
                        game_active  = 1'b1;
                        ch_enable    = 2'b11;
                        receive_done = {pct(3), pct(4)};
                        clear_stats  = pct(2);
                    end
                    3: begin
                        if (pct(5)) game_active = ~game_active;
                        receive_done = {pct(20), pct(20)};
                        clear_stats  = pct(1);
                    end
                    4: begin
                        game_active  = 1'b1;
                        ch_enable    = 2'b11;
                        receive_done = {pct(35), pct(35)};
                        clear_stats  = pct(20);
                    end
                    default: begin
                        game_active  = 1'b1;
                        if (pct(5)) ch_enable[0] = ~ch_enable[0];
                        if (pct(5)) ch_enable[1] = ~ch_enable[1];
                        receive_done = {pct(10), pct(10)};
                        clear_stats  = pct(3);
                    end
                endcase
                @(negedge clk);
                model_predict();
                check_outputs($sformatf("ph%0d", ph));
                @(posedge clk);
                model_commit();
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
